// File: rtl/mfcc_melbank_pkg.sv
// Mel filterbank tables and FSM state type shared by the controller and the bench.
// FILT_BASE holds cumulative filter lengths, so the weight ROM is packed with no gaps.
package mfcc_melbank_pkg;

   localparam int NUM_FILT_MAX = 64;
   localparam int NUM_FILT_CFG = 26;

   localparam int FILT_LEN [NUM_FILT_CFG] = '{
      10,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15, 16,
      17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 64};

   localparam int FILT_START [NUM_FILT_CFG] = '{
       0,  2,  4,  6,  8, 10, 12, 14, 16, 18, 20, 22, 24,
      26, 28, 30, 32, 34, 36, 38, 40, 42, 44, 46, 48, 50};

   localparam int FILT_BASE [NUM_FILT_CFG] = '{
        0,  10,  15,  21,  28,  36,  45,  55,  66,  78,  91, 105, 120,
      136, 153, 171, 190, 210, 231, 253, 276, 300, 325, 351, 378, 406};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_OUT,
      ST_DONE
   } state_t;

   // Table lookups written as explicit muxes so a 6-bit index never overruns the tables.
   function automatic int filt_len_f(input logic [5:0] m);
      filt_len_f = 0;
      for (int i = 0; i < NUM_FILT_CFG; i++)
         if (m == 6'(i)) filt_len_f = FILT_LEN[i];
   endfunction

   function automatic int filt_start_f(input logic [5:0] m);
      filt_start_f = 0;
      for (int i = 0; i < NUM_FILT_CFG; i++)
         if (m == 6'(i)) filt_start_f = FILT_START[i];
   endfunction

   function automatic int filt_base_f(input logic [5:0] m);
      filt_base_f = 0;
      for (int i = 0; i < NUM_FILT_CFG; i++)
         if (m == 6'(i)) filt_base_f = FILT_BASE[i];
   endfunction

endpackage

// File: rtl/mfcc_melbank_mac.sv
// Weight register, multiplier, accumulator and output reduction; MAC lands one cycle after issue.
// Output is acc>>8, wrapped to OUT_W, or saturated when MFCC_MELBANK_SAT_EN is defined.
module mfcc_melbank_mac #(
   parameter int SPEC_W = 32,
   parameter int WGT_W  = 8,
   parameter int ACC_W  = 48,
   parameter int OUT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wgt_ld,
   input  logic              acc_clr,
   input  logic [WGT_W-1:0]  rom_data,
   input  logic [SPEC_W-1:0] spec_data,
   output logic [OUT_W-1:0]  mel_data
);

   localparam int PROD_W = SPEC_W + WGT_W;

   logic [WGT_W-1:0]  wgt_q;
   logic              mac_en;
   logic [ACC_W-1:0]  acc;
   logic [PROD_W-1:0] prod;

   assign prod = PROD_W'(spec_data) * PROD_W'(wgt_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wgt_q  <= '0;
         mac_en <= 1'b0;
         acc    <= '0;
      end else begin
         mac_en <= wgt_ld;
         if (wgt_ld) wgt_q <= rom_data;
         if (acc_clr)     acc <= '0;
         else if (mac_en) acc <= acc + ACC_W'(prod);
      end
   end

`ifdef MFCC_MELBANK_SAT_EN
   logic [ACC_W-1:0] acc_sh;
   assign acc_sh   = acc >> 8;
   assign mel_data = ((acc_sh >> OUT_W) != '0) ? '1 : OUT_W'(acc_sh);
`else
   assign mel_data = OUT_W'(acc >> 8);
`endif

endmodule

// File: rtl/mfcc_melbank_ctrl.sv
// Mel filterbank sequencer: per filter L issue cycles, one drain, then mel_valid held until mel_ready.
// Filter cost L+2 cycles with mel_ready high; optional saturation via MFCC_MELBANK_SAT_EN.
module mfcc_melbank_ctrl
   import mfcc_melbank_pkg::*;
#(
   parameter int NUM_FILT = 26,
   parameter int SPEC_AW  = 9,
   parameter int ROM_AW   = 9,
   parameter int SPEC_W   = 32,
   parameter int WGT_W    = 8,
   parameter int ACC_W    = 48,
   parameter int OUT_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [ROM_AW-1:0]  rom_addr,
   input  logic [WGT_W-1:0]   rom_data,
   output logic [SPEC_AW-1:0] spec_addr,
   input  logic [SPEC_W-1:0]  spec_data,
   output logic [OUT_W-1:0]   mel_data,
   output logic [5:0]         mel_idx,
   output logic               mel_valid,
   input  logic               mel_ready
);

   state_t     state, state_nxt;
   logic [5:0] filt;
   logic [6:0] bin;
   logic [6:0] len_cur;
   logic       issue, last_bin, last_filt, hs;

   assign issue     = (state == ST_RUN);
   assign len_cur   = 7'(filt_len_f(filt));
   assign last_bin  = (bin == len_cur - 7'd1);
   assign last_filt = (filt == 6'(NUM_FILT - 1));
   assign hs        = (state == ST_OUT) && mel_ready;
   assign mel_idx   = filt;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      mel_valid = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (last_bin) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy      = 1'b1;
            state_nxt = ST_OUT;
         end
         ST_OUT: begin
            busy      = 1'b1;
            mel_valid = 1'b1;
            if (mel_ready) state_nxt = last_filt ? ST_DONE : ST_RUN;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Addresses are loaded one cycle ahead so each RUN cycle presents its own bin.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         filt      <= '0;
         bin       <= '0;
         rom_addr  <= '0;
         spec_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            filt      <= '0;
            bin       <= '0;
            rom_addr  <= ROM_AW'(filt_base_f(6'd0));
            spec_addr <= SPEC_AW'(filt_start_f(6'd0));
         end else if (issue && !last_bin) begin
            bin       <= bin + 7'd1;
            rom_addr  <= rom_addr + ROM_AW'(1);
            spec_addr <= spec_addr + SPEC_AW'(1);
         end else if (hs && !last_filt) begin
            filt      <= filt + 6'd1;
            bin       <= '0;
            rom_addr  <= ROM_AW'(filt_base_f(filt + 6'd1));
            spec_addr <= SPEC_AW'(filt_start_f(filt + 6'd1));
         end
      end
   end

   mfcc_melbank_mac #(
      .SPEC_W (SPEC_W),
      .WGT_W  (WGT_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .wgt_ld    (issue),
      .acc_clr   (issue && (bin == 7'd0)),
      .rom_data  (rom_data),
      .spec_data (spec_data),
      .mel_data  (mel_data)
   );

endmodule
